// File: rtl/test_card_pkg.sv
// ----------------------------------------------------------------------------
// test_card_pkg
// Shared definitions for the animated gradient test card.
//   mode_e        : pattern select encodings (STATIC, SCROLL, PULSE, GREY)
//   PIPE_LATENCY  : cycles from i_x/i_y/i_de to the colour outputs and o_de
// ----------------------------------------------------------------------------
package test_card_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SCROLL = 2'd1,
        MODE_PULSE  = 2'd2,
        MODE_GREY   = 2'd3
    } mode_e;

    localparam int unsigned PIPE_LATENCY = 2;

endpackage

// File: rtl/gradient_chan_add.sv
// ----------------------------------------------------------------------------
// gradient_chan_add
// Three-operand adder for one colour channel of the gradient test card.
// The sum is formed two bits wider than a channel, so three full-scale
// operands can never lose a carry, and is then reduced to channel width.
//
// Build option (macro TEST_CARD_GRADIENT_SAT_EN):
//   defined   : result clamps to all-ones when the wide sum overflows
//   undefined : result wraps modulo 2^CHAN_BITS
//
// Ports
//   a_i, b_i, c_i : CHAN_BITS operands
//   sum_o         : CHAN_BITS reduced sum (combinational)
// ----------------------------------------------------------------------------
module gradient_chan_add #(
    parameter int unsigned CHAN_BITS = 8
) (
    input  logic [CHAN_BITS-1:0] a_i,
    input  logic [CHAN_BITS-1:0] b_i,
    input  logic [CHAN_BITS-1:0] c_i,
    output logic [CHAN_BITS-1:0] sum_o
);

    logic [CHAN_BITS+1:0] sum_wide;

    always_comb begin
        sum_wide = {2'b00, a_i} + {2'b00, b_i} + {2'b00, c_i};
    end

`ifdef TEST_CARD_GRADIENT_SAT_EN
    always_comb begin
        if (|sum_wide[CHAN_BITS+1:CHAN_BITS]) begin
            sum_o = '1;
        end else begin
            sum_o = sum_wide[CHAN_BITS-1:0];
        end
    end
`else
    // Carry bits are intentionally discarded in the wrapping build.
    logic unused_carry;

    always_comb begin
        sum_o        = sum_wide[CHAN_BITS-1:0];
        unused_carry = ^sum_wide[CHAN_BITS+1:CHAN_BITS];
    end
`endif

endmodule

// File: rtl/test_card_gradient_anim.sv
// ----------------------------------------------------------------------------
// test_card_gradient_anim
// Animated gradient test card placed between the display timing generator and
// the video output encoder. Four patterns (STATIC, SCROLL, PULSE, GREY) and a
// per-frame offset that advances on each i_frame while i_anim_en is high.
// The requested mode is only sampled on i_frame, so a frame never tears.
//
// Pipeline: 2 cycles, no stall.
//   stage 1 : x_t, y_t (or scrolled y), de, mode/offset snapshot
//   stage 2 : channel sums, blanking, registered outputs and o_de
//
// Build option: TEST_CARD_GRADIENT_SAT_EN selects saturating channel sums
// (see gradient_chan_add); the default build wraps.
//
// Ports
//   i_clk       pixel clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_x, i_y    current pixel column / row
//   i_de        data enable (active video)
//   i_frame     start-of-frame pulse
//   i_mode      requested pattern, sampled on i_frame
//   i_anim_en   offset advances by STEP on i_frame when high
//   o_red, o_green, o_blue  colour channels (0 while blanked)
//   o_de        i_de delayed to line up with the colour channels
// ----------------------------------------------------------------------------
module test_card_gradient_anim
    import test_card_pkg::*;
#(
    parameter int unsigned          X_BITS    = 10,
    parameter int unsigned          Y_BITS    = 10,
    parameter int unsigned          CHAN_BITS = 8,
    parameter int unsigned          X_SHIFT   = 4,
    parameter int unsigned          Y_SHIFT   = 2,
    parameter logic [CHAN_BITS-1:0] STEP      = 1,
    parameter logic [CHAN_BITS-1:0] BASE_R    = 'h00,
    parameter logic [CHAN_BITS-1:0] BASE_G    = 'h10,
    parameter logic [CHAN_BITS-1:0] BASE_B    = 'h4C
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [X_BITS-1:0]    i_x,
    input  logic [Y_BITS-1:0]    i_y,
    input  logic                 i_de,
    input  logic                 i_frame,
    input  logic [1:0]           i_mode,
    input  logic                 i_anim_en,
    output logic [CHAN_BITS-1:0] o_red,
    output logic [CHAN_BITS-1:0] o_green,
    output logic [CHAN_BITS-1:0] o_blue,
    output logic                 o_de
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mode_e                mode_q,    mode_d;
    logic [CHAN_BITS-1:0] offset_q,  offset_d;

    logic [CHAN_BITS-1:0] s1_x_q,    s1_x_d;
    logic [CHAN_BITS-1:0] s1_y_q,    s1_y_d;
    logic                 s1_de_q,   s1_de_d;
    mode_e                s1_mode_q, s1_mode_d;
    logic [CHAN_BITS-1:0] s1_off_q,  s1_off_d;

    logic [CHAN_BITS-1:0] red_q,     red_d;
    logic [CHAN_BITS-1:0] green_q,   green_d;
    logic [CHAN_BITS-1:0] blue_q,    blue_d;
    logic                 de_q,      de_d;

    // ------------------------------------------------------------------
    // Frame logic: updates take effect for the pixel after the i_frame
    // cycle, since stage 1 snapshots the current (old) mode_q/offset_q.
    // ------------------------------------------------------------------
    always_comb begin
        mode_d   = mode_q;
        offset_d = offset_q;
        if (i_frame) begin
            mode_d = mode_e'(i_mode);
            if (i_anim_en) begin
                offset_d = offset_q + STEP;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: coordinate scaling and optional scroll of the row term
    // ------------------------------------------------------------------
    logic [CHAN_BITS-1:0] x_t;
    logic [CHAN_BITS-1:0] y_t;

    always_comb begin
        // Size casts truncate or zero-extend the shifted coordinate.
        x_t = CHAN_BITS'(i_x >> X_SHIFT);
        y_t = CHAN_BITS'(i_y >> Y_SHIFT);

        s1_x_d    = x_t;
        s1_de_d   = i_de;
        s1_mode_d = mode_q;
        s1_off_d  = offset_q;
        // The scrolled row always wraps, independent of saturation.
        if (mode_q == MODE_SCROLL) begin
            s1_y_d = y_t + offset_q;
        end else begin
            s1_y_d = y_t;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: operand selection per mode, channel adders, blanking
    // ------------------------------------------------------------------
    logic [CHAN_BITS-1:0] r_a, r_b, r_c;
    logic [CHAN_BITS-1:0] g_a, g_b, g_c;
    logic [CHAN_BITS-1:0] b_a, b_b, b_c;
    logic [CHAN_BITS-1:0] r_sum, g_sum, b_sum;

    always_comb begin
        r_a = '0;
        r_b = '0;
        r_c = '0;
        g_a = '0;
        g_b = '0;
        g_c = '0;
        b_a = '0;
        b_b = '0;
        b_c = '0;
        unique case (s1_mode_q)
            // SCROLL differs from STATIC only by the row term prepared in stage 1.
            MODE_STATIC, MODE_SCROLL: begin
                r_a = BASE_R;
                r_b = s1_y_q;
                r_c = s1_x_q;
                g_a = BASE_G;
                g_b = s1_y_q;
                b_a = BASE_B;
                b_b = s1_y_q;
            end
            MODE_PULSE: begin
                r_a = BASE_R;
                r_b = s1_off_q;
                g_a = BASE_G;
                g_b = s1_x_q;
                b_a = BASE_B;
                b_b = s1_y_q;
            end
            MODE_GREY: begin
                r_a = s1_x_q;
                r_b = s1_y_q;
                r_c = s1_off_q;
                g_a = s1_x_q;
                g_b = s1_y_q;
                g_c = s1_off_q;
                b_a = s1_x_q;
                b_b = s1_y_q;
                b_c = s1_off_q;
            end
            default: begin
            end
        endcase
    end

    gradient_chan_add #(
        .CHAN_BITS (CHAN_BITS)
    ) u_add_red (
        .a_i   (r_a),
        .b_i   (r_b),
        .c_i   (r_c),
        .sum_o (r_sum)
    );

    gradient_chan_add #(
        .CHAN_BITS (CHAN_BITS)
    ) u_add_green (
        .a_i   (g_a),
        .b_i   (g_b),
        .c_i   (g_c),
        .sum_o (g_sum)
    );

    gradient_chan_add #(
        .CHAN_BITS (CHAN_BITS)
    ) u_add_blue (
        .a_i   (b_a),
        .b_i   (b_b),
        .c_i   (b_c),
        .sum_o (b_sum)
    );

    always_comb begin
        de_d    = s1_de_q;
        red_d   = s1_de_q ? r_sum : '0;
        green_d = s1_de_q ? g_sum : '0;
        blue_d  = s1_de_q ? b_sum : '0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q    <= MODE_STATIC;
            offset_q  <= '0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_de_q   <= 1'b0;
            s1_mode_q <= MODE_STATIC;
            s1_off_q  <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            de_q      <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            offset_q  <= offset_d;
            s1_x_q    <= s1_x_d;
            s1_y_q    <= s1_y_d;
            s1_de_q   <= s1_de_d;
            s1_mode_q <= s1_mode_d;
            s1_off_q  <= s1_off_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            de_q      <= de_d;
        end
    end

    assign o_red   = red_q;
    assign o_green = green_q;
    assign o_blue  = blue_q;
    assign o_de    = de_q;

endmodule

// File: tb/tb_test_card_gradient_anim.sv
// ----------------------------------------------------------------------------
// tb_test_card_gradient_anim
// Directed bench for the animated gradient test card. Two instances share the
// stimulus: one with default bases and one with BASE_B = 'hF0 to reach the
// channel overflow corner. A pixel-level model predicts every output pixel,
// a negedge process compares both DUTs against it each cycle, and directed
// literal checks pin the model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_test_card_gradient_anim;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x     = '0;
    logic [9:0] y     = '0;
    logic       de    = 1'b0;
    logic       frame = 1'b0;
    logic [1:0] mode  = 2'd0;
    logic       anim  = 1'b0;

    logic [7:0] red, green, blue;
    logic       o_de;
    logic [7:0] red_s, green_s, blue_s;
    logic       o_de_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    test_card_gradient_anim dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_x       (x),
        .i_y       (y),
        .i_de      (de),
        .i_frame   (frame),
        .i_mode    (mode),
        .i_anim_en (anim),
        .o_red     (red),
        .o_green   (green),
        .o_blue    (blue),
        .o_de      (o_de)
    );

    test_card_gradient_anim #(
        .BASE_B (8'hF0)
    ) dut_sat (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_x       (x),
        .i_y       (y),
        .i_de      (de),
        .i_frame   (frame),
        .i_mode    (mode),
        .i_anim_en (anim),
        .o_red     (red_s),
        .o_green   (green_s),
        .o_blue    (blue_s),
        .o_de      (o_de_s)
    );

    // ------------------------------------------------------------------
    // Model: one expected pixel per input pixel, straight integer math
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       de;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] bs;
    } px_t;

    function automatic int reduce(input int v);
`ifdef TEST_CARD_GRADIENT_SAT_EN
        return (v > 255) ? 255 : v;
`else
        return v % 256;
`endif
    endfunction

    function automatic px_t model_px(input int xi, input int yi, input int dei,
                                     input int md, input int off);
        px_t p;
        int  xt, yt, yy, r, g, b, bs;
        xt = (xi / 16) % 256;
        yt = (yi / 4) % 256;
        p  = '0;
        if (dei == 0) return p;
        yy = (md == 1) ? (yt + off) % 256 : yt;
        case (md)
            0, 1: begin
                r  = 'h00 + yy + xt;
                g  = 'h10 + yy;
                b  = 'h4C + yy;
                bs = 'hF0 + yy;
            end
            2: begin
                r  = 'h00 + off;
                g  = 'h10 + xt;
                b  = 'h4C + yt;
                bs = 'hF0 + yt;
            end
            default: begin
                r  = xt + yt + off;
                g  = r;
                b  = r;
                bs = r;
            end
        endcase
        p.de = 1'b1;
        p.r  = 8'(reduce(r));
        p.g  = 8'(reduce(g));
        p.b  = 8'(reduce(b));
        p.bs = 8'(reduce(bs));
        return p;
    endfunction

    px_t m_p1, m_p2;
    int  m_mode, m_off;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p1   <= '0;
            m_p2   <= '0;
            m_mode <= 0;
            m_off  <= 0;
        end else begin
            m_p1 <= model_px(int'(x), int'(y), int'(de), m_mode, m_off);
            m_p2 <= m_p1;
            if (frame) begin
                m_mode <= int'(mode);
                if (anim) m_off <= (m_off + 1) % 256;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("cmp_de",      int'(o_de),    int'(m_p2.de));
        check("cmp_red",     int'(red),     int'(m_p2.r));
        check("cmp_green",   int'(green),   int'(m_p2.g));
        check("cmp_blue",    int'(blue),    int'(m_p2.b));
        check("cmp_sat_de",  int'(o_de_s),  int'(m_p2.de));
        check("cmp_sat_red", int'(red_s),   int'(m_p2.r));
        check("cmp_sat_grn", int'(green_s), int'(m_p2.g));
        check("cmp_sat_blu", int'(blue_s),  int'(m_p2.bs));
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int xi, input int yi, input bit dei, input bit fr,
                         input int md, input bit an);
        x     = 10'(xi);
        y     = 10'(yi);
        de    = dei;
        frame = fr;
        mode  = 2'(md);
        anim  = an;
    endtask

    task automatic expect_rgb(input string name, input int r, input int g, input int b);
        check({name, "_de"}, int'(o_de),  1);
        check({name, "_r"},  int'(red),   r);
        check({name, "_g"},  int'(green), g);
        check({name, "_b"},  int'(blue),  b);
    endtask

    int sr, sg, sb;
    int exp_b, exp_bs;

    initial begin
        // Reset held with random inputs: outputs stay cleared.
        for (int i = 0; i < 5; i++) begin
            drive(int'($urandom_range(1023)), int'($urandom_range(1023)),
                  1'($urandom), 1'($urandom), int'($urandom_range(3)), 1'($urandom));
            tick();
            check("rst_de", int'(o_de), 0);
            check("rst_rgb", int'({red, green, blue}), 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // STATIC, x=16 y=8: first o_de exactly 2 cycles after first i_de.
        drive(16, 8, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("lat_one_cycle_de", int'(o_de), 0);
        tick();
        expect_rgb("static", 'h03, 'h12, 'h4E);
        tick();
        check("lat_de_drop", int'(o_de), 0);

        // SCROLL after three animated frame pulses, pixel at origin.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 1, 1);
            tick();
        end
        drive(0, 0, 1, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        tick();
        expect_rgb("scroll", 'h03, 'h13, 'h4F);

        // 253 more pulses (frame held high) bring the offset back to 0.
        drive(0, 0, 0, 1, 1, 1);
        repeat (253) tick();
        drive(16, 8, 1, 0, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        tick();
        expect_rgb("wrap_scroll", 'h03, 'h12, 'h4E);
        sr = int'(red);
        sg = int'(green);
        sb = int'(blue);
        drive(16, 8, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("wrap_eq_r", int'(red),   sr);
        check("wrap_eq_g", int'(green), sg);
        check("wrap_eq_b", int'(blue),  sb);

        // GREY requested mid-frame is ignored until i_frame; the i_frame
        // pixel itself still renders STATIC.
        drive(48, 4, 1, 0, 3, 0);
        tick();
        drive(48, 4, 1, 1, 3, 0);
        tick();
        expect_rgb("midframe_static", 'h04, 'h11, 'h4D);
        drive(48, 4, 1, 0, 3, 0);
        tick();
        expect_rgb("frame_pixel_old", 'h04, 'h11, 'h4D);
        drive(0, 0, 0, 0, 3, 0);
        tick();
        expect_rgb("first_grey", 'h04, 'h04, 'h04);

        // Channel overflow: y = 'h3FC -> y_t = 'hFF.
        drive(0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 'h3FC, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
`ifdef TEST_CARD_GRADIENT_SAT_EN
        exp_b  = 'hFF;
        exp_bs = 'hFF;
`else
        exp_b  = 'h4B;
        exp_bs = 'hEF;
`endif
        check("ovf_blue_sat_inst", int'(blue_s), exp_bs);
        check("ovf_blue_default",  int'(blue),   exp_b);

        // Blanking with nonzero coordinates.
        drive('h3FF, 'h3FF, 0, 0, 0, 0);
        tick();
        tick();
        check("blank_de",  int'(o_de), 0);
        check("blank_rgb", int'({red, green, blue}), 0);

        // Random traffic, checked by the compare process.
        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom_range(1023)), int'($urandom_range(1023)),
                  1'($urandom_range(3) != 0), 1'($urandom_range(15) == 0),
                  int'($urandom_range(3)), 1'($urandom));
            tick();
        end

        // Mid-frame reset: mode/offset cleared, o_de low for 2 cycles after release.
        drive(16, 8, 1, 1, 3, 1);
        tick();
        drive(16, 8, 1, 0, 3, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_de",  int'(o_de), 0);
        check("midrst_rgb", int'({red, green, blue}), 0);
        tick();
        rst_n = 1'b1;
        drive(16, 8, 1, 0, 0, 0);
        tick();
        check("rel_de_c1", int'(o_de), 0);
        tick();
        expect_rgb("after_rst", 'h03, 'h12, 'h4E);

        drive(0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
